instr_encoder: RTL and testbench

- Writes a program into instruction memory, in the opposite direction to the instruction decoder.
- Accepts symbolic instruction requests (operation, register fields, immediate) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes it to consecutive instruction-memory addresses.
- Sits between the testbench/boot loader and instruction memory; the words it produces are the decoder's input.

---
 rtl/instr_enc_pkg.sv | 48 ++++
 rtl/instr_pack.sv | 53 +++++
 rtl/instr_encoder.sv | 133 +++++++++++++
 tb/tb_instr_encoder.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types for the instruction encoder: op codes, MIPS opcode/funct fields
// and the loader FSM state.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_ADDU  = 4'd1,
        OP_SUB   = 4'd2,
        OP_SUBU  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOR   = 4'd7,
        OP_SLT   = 4'd8,
        OP_ADDI  = 4'd9,
        OP_LW    = 4'd10,
        OP_SW    = 4'd11,
        OP_BEQ   = 4'd12,
        OP_BNE   = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PAD  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op plus register/immediate fields into a
// 32-bit MIPS word, flagging the two unassigned op codes as illegal.
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    logic [5:0] w_funct;
    logic [5:0] w_opc;
    logic       w_rtype;

    always_comb begin
        w_funct   = 6'b000000;
        w_opc     = OPC_RTYPE;
        w_rtype   = 1'b0;
        o_illegal = 1'b0;
        case (op_e'(i_op))
            OP_ADD:  begin w_rtype = 1'b1; w_funct = FUNCT_ADD;  end
            OP_ADDU: begin w_rtype = 1'b1; w_funct = FUNCT_ADDU; end
            OP_SUB:  begin w_rtype = 1'b1; w_funct = FUNCT_SUB;  end
            OP_SUBU: begin w_rtype = 1'b1; w_funct = FUNCT_SUBU; end
            OP_AND:  begin w_rtype = 1'b1; w_funct = FUNCT_AND;  end
            OP_OR:   begin w_rtype = 1'b1; w_funct = FUNCT_OR;   end
            OP_XOR:  begin w_rtype = 1'b1; w_funct = FUNCT_XOR;  end
            OP_NOR:  begin w_rtype = 1'b1; w_funct = FUNCT_NOR;  end
            OP_SLT:  begin w_rtype = 1'b1; w_funct = FUNCT_SLT;  end
            OP_ADDI: w_opc = OPC_ADDI;
            OP_LW:   w_opc = OPC_LW;
            OP_SW:   w_opc = OPC_SW;
            OP_BEQ:  w_opc = OPC_BEQ;
            OP_BNE:  w_opc = OPC_BNE;
            default: o_illegal = 1'b1;
        endcase
    end

    // R-type drops the immediate, I-type drops rd; illegal ops yield an all-zero word.
    always_comb begin
        o_word = 32'h0000_0000;
        if (w_rtype) begin
            o_word = {OPC_RTYPE, i_rs, i_rt, i_rd, 5'b00000, w_funct};
        end else if (!o_illegal) begin
            o_word = {w_opc, i_rs, i_rt, i_imm};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs symbolic requests into MIPS words and writes them to
// consecutive instruction-memory addresses. Define INSTR_PAD_EN to NOP-fill the tail.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              err_illegal,
    output logic [ADDR_W:0]   instr_count
);

`ifdef INSTR_PAD_EN
    localparam state_e END_STATE = ST_PAD;
`else
    localparam state_e END_STATE = ST_DONE;
`endif

    state_e            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_accept;
    logic              w_at_end;

    instr_pack u_pack (
        .i_op      (in_op),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_imm     (in_imm),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    assign in_ready = (r_state == ST_LOAD) && !start;
    assign w_accept = in_valid && in_ready;
    assign w_at_end = (r_ptr == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= 1'b0;
            // start restarts from any state; the write registered last cycle is already on the outputs
            if (start) begin
                r_state <= ST_LOAD;
                r_ptr   <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_accept) begin
                            if (w_illegal) begin
                                r_err <= 1'b1;
                                if (in_last) r_state <= END_STATE;
                            end else begin
                                r_we    <= 1'b1;
                                r_addr  <= r_ptr;
                                r_wdata <= w_word;
                                r_ptr   <= r_ptr + 1'b1;
                                r_count <= r_count + 1'b1;
                                if (w_at_end) begin
                                    r_state <= ST_DONE;
                                    r_full  <= 1'b1;
                                end else if (in_last) begin
                                    r_state <= END_STATE;
                                end
                            end
                        end
                    end
`ifdef INSTR_PAD_EN
                    ST_PAD: begin
                        r_we    <= 1'b1;
                        r_addr  <= r_ptr;
                        r_wdata <= 32'h0000_0000;
                        r_ptr   <= r_ptr + 1'b1;
                        r_count <= r_count + 1'b1;
                        if (w_at_end) begin
                            r_state <= ST_DONE;
                            r_full  <= 1'b1;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign im_we       = r_we;
    assign im_addr     = r_addr;
    assign im_wdata    = r_wdata;
    assign busy        = (r_state == ST_LOAD) || (r_state == ST_PAD);
    assign done        = (r_state == ST_DONE);
    assign full        = r_full;
    assign err_illegal = r_err;
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected writes, a monitor
// pops and compares each instruction-memory write.
module tb_instr_encoder;

    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_op = 4'd0;
    logic [4:0]        in_rs = 5'd0;
    logic [4:0]        in_rt = 5'd0;
    logic [4:0]        in_rd = 5'd0;
    logic [15:0]       in_imm = 16'd0;
    logic              in_last = 1'b0;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              busy;
    logic              done;
    logic              full;
    logic              err_illegal;
    logic [ADDR_W:0]   instr_count;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rs       (in_rs),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .busy        (busy),
        .done        (done),
        .full        (full),
        .err_illegal (err_illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    logic [37:0] sb[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && im_we) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr=%0d data=0x%08h, expected no write", im_addr, im_wdata);
            end else begin
                logic [37:0] e;
                e = sb.pop_front();
                chk("wr_addr", 64'(im_addr), 64'(e[37:32]));
                chk("wr_data", 64'(im_wdata), 64'(e[31:0]));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last,
                        input logic wr, input logic [5:0] a, input logic [31:0] w);
        bit accepted = 1'b0;
        @(negedge clk);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                if (wr) sb.push_back({a, w});
                @(posedge clk);
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!accepted) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
    endtask

    // A legal ADD is held valid during the start cycle; any acceptance would show up as a stray write.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b1; in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3; in_last = 1'b0;
        #1;
        chk("ready_in_start_cycle", 64'(in_ready), 64'd0);
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        #1;
    endtask

    task automatic pad_from(input int a);
`ifdef INSTR_PAD_EN
        for (int i = a; i < 64; i++) sb.push_back({6'(i), 32'h0000_0000});
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("pad_done", 64'(done), 64'd1);
        chk("pad_full", 64'(full), 64'd1);
`else
        if (a < 0) $display("pad_from: negative address %0d", a);
`endif
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we",    64'(im_we),       64'd0);
        chk("rst_addr",  64'(im_addr),     64'd0);
        chk("rst_wdata", 64'(im_wdata),    64'd0);
        chk("rst_count", 64'(instr_count), 64'd0);
        chk("rst_busy",  64'(busy),        64'd0);
        chk("rst_done",  64'(done),        64'd0);
        chk("rst_full",  64'(full),        64'd0);
        chk("rst_err",   64'(err_illegal), 64'd0);
        chk("rst_ready", 64'(in_ready),    64'd0);
        rst_n = 1'b1;

        // Requests in IDLE are ignored
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);

        // Single ADD
        pulse_start();
        chk("load_busy",  64'(busy),     64'd1);
        chk("load_ready", 64'(in_ready), 64'd1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 6'd0, 32'h0022_1820);
        idle();
        chk("add_count", 64'(instr_count), 64'd1);

        // LW, SW back-to-back, BEQ with last
        pulse_start();
        chk("restart_count", 64'(instr_count), 64'd0);
        send(4'd10, 5'd29, 5'd8,  5'd0, 16'h0010, 1'b0, 1'b1, 6'd0, 32'h8FA8_0010);
        send(4'd11, 5'd29, 5'd31, 5'd0, 16'h0004, 1'b0, 1'b1, 6'd1, 32'hAFBF_0004);
        idle();
        chk("lwsw_count", 64'(instr_count), 64'd2);
        send(4'd12, 5'd4, 5'd5, 5'd0, 16'hFFFE, 1'b1, 1'b1, 6'd2, 32'h1085_FFFE);
        pad_from(3);
        idle();
`ifdef INSTR_PAD_EN
        chk("beq_count", 64'(instr_count), 64'd64);
`else
        chk("beq_done",  64'(done),        64'd1);
        chk("beq_ready", 64'(in_ready),    64'd0);
        chk("beq_busy",  64'(busy),        64'd0);
        chk("beq_count", 64'(instr_count), 64'd3);
        chk("beq_full",  64'(full),        64'd0);
        in_valid = 1'b1; in_op = 4'd0;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("done_hold", 64'(done), 64'd1);
`endif

        // Illegal op between legal ones; R-type imm and I-type rd are ignored
        pulse_start();
        send(4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 1'b0, 1'b1, 6'd0, 32'h0022_1820);
        send(4'd14, 5'd7,  5'd7,  5'd7,  16'h1234, 1'b0, 1'b0, 6'd0, 32'h0);
        send(4'd0,  5'd4,  5'd5,  5'd6,  16'hBEEF, 1'b0, 1'b1, 6'd1, 32'h0085_3020);
        send(4'd6,  5'd7,  5'd8,  5'd9,  16'h0000, 1'b0, 1'b1, 6'd2, 32'h00E8_4826);
        send(4'd8,  5'd10, 5'd11, 5'd12, 16'h0000, 1'b0, 1'b1, 6'd3, 32'h014B_602A);
        send(4'd13, 5'd3,  5'd0,  5'd31, 16'h0008, 1'b0, 1'b1, 6'd4, 32'h1460_0008);
        send(4'd9,  5'd0,  5'd1,  5'd7,  16'h7FFF, 1'b1, 1'b1, 6'd5, 32'h2001_7FFF);
        pad_from(6);
        idle();
        chk("ill_err",  64'(err_illegal), 64'd1);
        chk("ill_done", 64'(done),        64'd1);
`ifdef INSTR_PAD_EN
        chk("ill_count", 64'(instr_count), 64'd64);
`else
        chk("ill_count", 64'(instr_count), 64'd6);
`endif

        // Illegal op carrying last ends the load
        pulse_start();
        chk("err_cleared", 64'(err_illegal), 64'd0);
        send(4'd0,  5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 6'd0, 32'h0022_1820);
        send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b0, 6'd0, 32'h0);
        pad_from(1);
        idle();
        chk("illast_done", 64'(done),        64'd1);
        chk("illast_err",  64'(err_illegal), 64'd1);
`ifdef INSTR_PAD_EN
        chk("illast_count", 64'(instr_count), 64'd64);
`else
        chk("illast_count", 64'(instr_count), 64'd1);
`endif

        // Restart mid-load
        pulse_start();
        for (int i = 0; i < 3; i++)
            send(4'd9, 5'd0, 5'd1, 5'd0, 16'(i), 1'b0, 1'b1, 6'(i), 32'h2001_0000 + 32'(i));
        send(4'd14, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 6'd0, 32'h0);
        pulse_start();
        chk("mid_count", 64'(instr_count), 64'd0);
        chk("mid_err",   64'(err_illegal), 64'd0);
        chk("mid_busy",  64'(busy),        64'd1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 6'd0, 32'h0022_1820);
        idle();
        chk("mid_count1", 64'(instr_count), 64'd1);

        // Fill all 64 addresses without last
        pulse_start();
        for (int i = 0; i < 64; i++)
            send(4'd9, 5'd0, 5'd1, 5'd0, 16'(i), 1'b0, 1'b1, 6'(i), 32'h2001_0000 + 32'(i));
        idle();
        chk("full_done",  64'(done),        64'd1);
        chk("full_full",  64'(full),        64'd1);
        chk("full_count", 64'(instr_count), 64'd64);
        chk("full_ready", 64'(in_ready),    64'd0);

        // Reset mid-load
        pulse_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0, 1'b1, 6'd0, 32'h0022_1820);
        send(4'd0, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b0, 1'b1, 6'd1, 32'h0085_3020);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_we",    64'(im_we),       64'd0);
        chk("mrst_addr",  64'(im_addr),     64'd0);
        chk("mrst_wdata", 64'(im_wdata),    64'd0);
        chk("mrst_count", 64'(instr_count), 64'd0);
        chk("mrst_busy",  64'(busy),        64'd0);
        chk("mrst_ready", 64'(in_ready),    64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
